adder_tree_acc: RTL and testbench

Parametrised, fully pipelined signed adder tree: reduces N lane values of IW bits per beat, then accumulates beat sums over a multi-beat frame delimited by first/last flags. It is the generalised successor of the fixed 36-lane reduction in the MAC core. It serves any channel count and partial-sum depth, with optional saturation and an overflow flag. It sits between the multiplier array and the output quantiser.

---
 rtl/adder_tree_acc.sv | 124 ++++++++++++
 tb/tb_adder_tree_acc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree (clog2(N) registered levels) feeding a framed
// accumulator with optional saturation, sticky overflow and partial-frame drop.
module adder_tree_acc #(
  parameter int unsigned N   = 36,
  parameter int unsigned IW  = 16,
  parameter int unsigned OW  = 32,
  parameter bit          SAT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_i,
  input  logic                 first_i,
  input  logic                 last_i,
  input  logic [N*IW-1:0]      din,
  output logic signed [OW-1:0] acc_o,
  output logic                 vld_o,
  output logic                 ovf_o,
  output logic                 drop_o
);

  localparam int unsigned LV = $clog2(N);
  localparam int unsigned SW = IW + LV;
  localparam logic [OW-1:0] SMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] SMIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  // Every level is held at the final tree width; operands are sign-extended,
  // so the sums are identical to growing the width by one bit per level.
  // Arrays are 2N deep so the pairing index 2k+1 never leaves the range.
  logic signed [SW-1:0] lane [0:2*N-1];

  always_comb begin
    for (int unsigned k = 0; k < 2*N; k++) lane[k] = '0;
    for (int unsigned k = 0; k < N; k++)   lane[k] = SW'($signed(din[k*IW +: IW]));
  end

  for (genvar j = 1; j <= LV; j++) begin : g_lvl
    localparam int unsigned CUR = (N + (1 << j) - 1) >> j;
    localparam int unsigned PRV = (N + (1 << (j-1)) - 1) >> (j-1);
    logic signed [SW-1:0] src [0:2*N-1];
    logic signed [SW-1:0] r   [0:2*N-1];

    if (j == 1) begin : g_src
      always_comb src = lane;
    end else begin : g_src
      always_comb src = g_lvl[j-1].r;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned k = 0; k < 2*N; k++) r[k] <= '0;
      end else begin
        for (int unsigned k = CUR; k < 2*N; k++) r[k] <= '0;
        for (int unsigned k = 0; k < CUR; k++)
          r[k] <= (2*k + 1 < PRV) ? src[2*k] + src[2*k+1] : src[2*k];
      end
    end
  end

  logic signed [SW-1:0] tsum;
  assign tsum = g_lvl[LV].r[0];

  logic [2:0] ctl [0:LV-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < LV; j++) ctl[j] <= '0;
    end else begin
      ctl[0] <= {vld_i, first_i, last_i};
      for (int unsigned j = 1; j < LV; j++) ctl[j] <= ctl[j-1];
    end
  end

  state_t               state, state_nx;
  logic                 b_vld, b_first, b_last;
  logic                 start, drop, ovf_now, sticky_q, sticky_nx;
  logic signed [OW:0]   sum_x, base, res;
  logic signed [OW-1:0] acc_q, new_val;

  always_comb begin
    {b_vld, b_first, b_last} = ctl[LV-1];
    // A non-first beat in IDLE starts a frame implicitly.
    start     = b_vld && (b_first || state == IDLE);
    drop      = b_vld && b_first && state == ACC;
    sum_x     = (OW+1)'(tsum);
    base      = start ? '0 : (OW+1)'(acc_q);
    res       = base + sum_x;
    ovf_now   = b_vld && (res[OW] != res[OW-1]);
    new_val   = res[OW-1:0];
    if (SAT && ovf_now) new_val = res[OW] ? SMIN : SMAX;
    sticky_nx = (start ? 1'b0 : sticky_q) | ovf_now;
    state_nx  = state;
    if (b_vld) state_nx = b_last ? IDLE : ACC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      acc_o    <= '0;
      vld_o    <= 1'b0;
      ovf_o    <= 1'b0;
      drop_o   <= 1'b0;
    end else begin
      vld_o  <= b_vld && b_last;
      drop_o <= drop;
      if (b_vld) begin
        acc_q    <= new_val;
        sticky_q <= sticky_nx;
        if (b_last) begin
          acc_o <= new_val;
          ovf_o <= sticky_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench: drivers push expected results with their due cycle,
// per-DUT monitors pop and compare whenever vld_o or drop_o fires.
module tb_adder_tree_acc;

  localparam int unsigned NA = 36;
  localparam int unsigned IA = 16;
  localparam int unsigned ND = 5;
  localparam int unsigned ID = 8;
  localparam int unsigned LAT36 = 7;
  localparam int unsigned LAT5  = 4;

  typedef struct {
    longint      acc;
    bit          ovf;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;

  exp_t qa[$], qb[$], qc[$], qd[$];
  int unsigned qdrop[$];
  exp_t ea, eb, ec, ed;

  // DUT A: N=36 OW=32 SAT=1
  logic                 vld_a = 0, first_a = 0, last_a = 0;
  logic [NA*IA-1:0]     din_a = '0;
  logic signed [31:0]   acc_a;
  logic                 vo_a, ovf_a, drop_a;
  // DUT B/C: N=36 OW=24, SAT=1 and SAT=0, shared stimulus
  logic                 vld_b = 0, first_b = 0, last_b = 0;
  logic [NA*IA-1:0]     din_b = '0;
  logic signed [23:0]   acc_b, acc_c;
  logic                 vo_b, ovf_b, drop_b, vo_c, ovf_c, drop_c;
  // DUT D: N=5 IW=8 OW=12
  logic                 vld_d = 0, first_d = 0, last_d = 0;
  logic [ND*ID-1:0]     din_d = '0;
  logic signed [11:0]   acc_d;
  logic                 vo_d, ovf_d, drop_d;

  adder_tree_acc #(.N(NA), .IW(IA), .OW(32), .SAT(1'b1)) u_a (
    .clk(clk), .rst(rst), .vld_i(vld_a), .first_i(first_a), .last_i(last_a), .din(din_a),
    .acc_o(acc_a), .vld_o(vo_a), .ovf_o(ovf_a), .drop_o(drop_a));
  adder_tree_acc #(.N(NA), .IW(IA), .OW(24), .SAT(1'b1)) u_b (
    .clk(clk), .rst(rst), .vld_i(vld_b), .first_i(first_b), .last_i(last_b), .din(din_b),
    .acc_o(acc_b), .vld_o(vo_b), .ovf_o(ovf_b), .drop_o(drop_b));
  adder_tree_acc #(.N(NA), .IW(IA), .OW(24), .SAT(1'b0)) u_c (
    .clk(clk), .rst(rst), .vld_i(vld_b), .first_i(first_b), .last_i(last_b), .din(din_b),
    .acc_o(acc_c), .vld_o(vo_c), .ovf_o(ovf_c), .drop_o(drop_c));
  adder_tree_acc #(.N(ND), .IW(ID), .OW(12), .SAT(1'b1)) u_d (
    .clk(clk), .rst(rst), .vld_i(vld_d), .first_i(first_d), .last_i(last_d), .din(din_d),
    .acc_o(acc_d), .vld_o(vo_d), .ovf_o(ovf_d), .drop_o(drop_d));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=pulse exp=none (cyc %0d)", name, cyc);
  endtask

  always @(negedge clk) if (!rst && vo_a) begin
    if (qa.size() == 0) unexpected("vld_a");
    else begin
      ea = qa.pop_front();
      chk("acc_a", longint'(acc_a), ea.acc);
      chk("ovf_a", longint'(ovf_a), longint'(ea.ovf));
      chk("lat_a", longint'(cyc), longint'(ea.cyc));
    end
  end

  always @(negedge clk) if (!rst && vo_b) begin
    if (qb.size() == 0) unexpected("vld_b");
    else begin
      eb = qb.pop_front();
      chk("acc_b_sat", longint'(acc_b), eb.acc);
      chk("ovf_b_sat", longint'(ovf_b), longint'(eb.ovf));
      chk("lat_b", longint'(cyc), longint'(eb.cyc));
    end
  end

  always @(negedge clk) if (!rst && vo_c) begin
    if (qc.size() == 0) unexpected("vld_c");
    else begin
      ec = qc.pop_front();
      chk("acc_c_wrap", longint'(acc_c), ec.acc);
      chk("ovf_c_wrap", longint'(ovf_c), longint'(ec.ovf));
      chk("lat_c", longint'(cyc), longint'(ec.cyc));
    end
  end

  always @(negedge clk) if (!rst && vo_d) begin
    if (qd.size() == 0) unexpected("vld_d");
    else begin
      ed = qd.pop_front();
      chk("acc_d", longint'(acc_d), ed.acc);
      chk("ovf_d", longint'(ovf_d), longint'(ed.ovf));
      chk("lat_d", longint'(cyc), longint'(ed.cyc));
    end
  end

  always @(negedge clk) if (!rst) begin
    if (drop_a) begin
      if (qdrop.size() == 0) unexpected("drop_a");
      else chk("drop_a_cyc", longint'(cyc), longint'(qdrop.pop_front()));
    end
    if (drop_b || drop_c || drop_d) unexpected("drop_bcd");
  end

  function automatic logic [NA*IA-1:0] fill36(input int v);
    logic [NA*IA-1:0] r;
    for (int k = 0; k < NA; k++) r[k*IA +: IA] = 16'(v);
    return r;
  endfunction

  function automatic logic [NA*IA-1:0] ramp36();
    logic [NA*IA-1:0] r;
    for (int k = 0; k < NA; k++) r[k*IA +: IA] = 16'(k);
    return r;
  endfunction

  // Called at a negedge; the beat is captured at the next posedge.
  task automatic beat_a(input logic [NA*IA-1:0] d, input logic f, input logic l,
                        input bit exp_drop, input longint exp_acc, input bit exp_ovf);
    exp_t e;
    vld_a = 1; din_a = d; first_a = f; last_a = l;
    if (l) begin
      e.acc = exp_acc; e.ovf = exp_ovf; e.cyc = cyc + LAT36;
      qa.push_back(e);
    end
    if (exp_drop) qdrop.push_back(cyc + LAT36);
    @(negedge clk);
    vld_a = 0; first_a = 0; last_a = 0;
  endtask

  task automatic beat_bc(input logic [NA*IA-1:0] d, input logic f, input logic l,
                         input longint acc_sat, input longint acc_wrap, input bit exp_ovf);
    exp_t e;
    vld_b = 1; din_b = d; first_b = f; last_b = l;
    if (l) begin
      e.ovf = exp_ovf; e.cyc = cyc + LAT36;
      e.acc = acc_sat;  qb.push_back(e);
      e.acc = acc_wrap; qc.push_back(e);
    end
    @(negedge clk);
    vld_b = 0; first_b = 0; last_b = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [NA*IA-1:0] ones;
    exp_t e;
    ones = fill36(1);

    idle(2);
    chk("rst_acc_a", longint'(acc_a), 0);
    chk("rst_vld_a", longint'(vo_a), 0);
    chk("rst_ovf_a", longint'(ovf_a), 0);
    chk("rst_drop_a", longint'(drop_a), 0);
    chk("rst_acc_d", longint'(acc_d), 0);
    rst = 0;
    idle(2);

    beat_a(ones, 1, 1, 0, 36, 0);
    idle(10);
    chk("acc_a_held", longint'(acc_a), 36);

    beat_a(fill36(-32768), 1, 1, 0, -1179648, 0);
    beat_a(fill36(32767),  1, 1, 0, 1179612, 0);
    idle(10);

    beat_a(ramp36(), 1, 0, 0, 0, 0);
    beat_a(ramp36(), 0, 0, 0, 0, 0);
    beat_a(ramp36(), 0, 1, 0, 1890, 0);
    beat_a(ramp36(), 1, 1, 0, 630, 0);
    idle(10);

    beat_a(ones, 1, 0, 0, 0, 0);
    beat_a(ones, 0, 0, 0, 0, 0);
    beat_a(ones, 1, 0, 1, 0, 0);
    beat_a(ones, 0, 1, 0, 72, 0);
    idle(10);
    beat_a(ones, 0, 1, 0, 36, 0);
    idle(10);

    for (int i = 0; i < 8; i++)
      beat_bc(fill36(32767), i == 0, i == 7, 8388607, -7340320, 1);
    beat_bc(ones, 1, 1, 36, 36, 0);
    idle(10);

    vld_d = 1; first_d = 1; last_d = 1;
    din_d = {8'h80, 8'd4, 8'd3, 8'd2, 8'd1};
    e.acc = -118; e.ovf = 0; e.cyc = cyc + LAT5;
    qd.push_back(e);
    @(negedge clk);
    vld_d = 0; first_d = 0; last_d = 0;
    idle(10);

    beat_a(ones, 1, 0, 0, 0, 0);
    beat_a(ones, 0, 0, 0, 0, 0);
    rst = 1;
    #1;
    chk("midrst_acc_a", longint'(acc_a), 0);
    chk("midrst_vld_a", longint'(vo_a), 0);
    chk("midrst_ovf_a", longint'(ovf_a), 0);
    chk("midrst_drop_a", longint'(drop_a), 0);
    chk("midrst_acc_b", longint'(acc_b), 0);
    @(negedge clk);
    rst = 0;
    idle(12);
    beat_a(ones, 1, 0, 0, 0, 0);
    beat_a(ones, 0, 1, 0, 72, 0);

    for (int i = 0; i < 40; i++) begin
      if (qa.size() + qb.size() + qc.size() + qd.size() + qdrop.size() == 0) break;
      @(negedge clk);
    end
    idle(3);
    chk("pending_a", longint'(qa.size()), 0);
    chk("pending_bc", longint'(qb.size() + qc.size()), 0);
    chk("pending_d", longint'(qd.size()), 0);
    chk("pending_drop", longint'(qdrop.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
